// File: rtl/serial_add_ctrl_if.sv
// Handshake and data bundle for the bit-serial adder: operands and start in, result and status out.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] Sum;
   logic             Carry;
   logic             busy;
   logic             done;

   modport master (
      output start, A, B,
      input  Sum, Carry, busy, done
   );

   modport slave (
      input  start, A, B,
      output Sum, Carry, busy, done
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: a single full-adder cell built from two half adders walks the
// operands LSB first, one bit per clock, under a three-state IDLE/RUN/FIN controller.
module ha (
   input  logic A,
   input  logic B,
   output logic Su,
   output logic Ca
);
   assign Su = A ^ B;
   assign Ca = A & B;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   serial_add_ctrl_if.slave bus
);
   localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] ws_r;
   logic [WIDTH-1:0] sum_r;
   logic [CW-1:0]    cnt_r;
   logic             c_r;
   logic             carry_r;
   logic             busy_r;
   logic             done_r;

   logic             ha0_su_s;
   logic             ha0_ca_s;
   logic             fa_sum_s;
   logic             ha1_ca_s;
   logic             fa_carry_s;
   logic [WIDTH-1:0] ws_nxt_s;

   ha u_ha0 (.A(a_sh_r[0]), .B(b_sh_r[0]), .Su(ha0_su_s), .Ca(ha0_ca_s));
   ha u_ha1 (.A(ha0_su_s),  .B(c_r),       .Su(fa_sum_s), .Ca(ha1_ca_s));

   assign fa_carry_s = ha0_ca_s | ha1_ca_s;

   // Working sum with the current result bit entering at the MSB.
   always_comb begin
      ws_nxt_s           = ws_r >> 1'b1;
      ws_nxt_s[WIDTH-1]  = fa_sum_s;
   end

   // Controller, datapath shift registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         a_sh_r  <= {WIDTH{1'b0}};
         b_sh_r  <= {WIDTH{1'b0}};
         ws_r    <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
         c_r     <= 1'b0;
         carry_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a_sh_r  <= bus.A;
                  b_sh_r  <= bus.B;
                  c_r     <= 1'b0;
                  cnt_r   <= {CW{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               a_sh_r <= a_sh_r >> 1'b1;
               b_sh_r <= b_sh_r >> 1'b1;
               ws_r   <= ws_nxt_s;
               c_r    <= fa_carry_s;
               cnt_r  <= cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  sum_r   <= ws_nxt_s;
                  carry_r <= fa_carry_s;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= FIN;
               end else begin
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  state_r <= RUN;
               end
            end
            FIN: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.Sum   = sum_r;
   assign bus.Carry = carry_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 with directed vectors.
module tb_serial_add_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_add_ctrl_if #(.WIDTH(8)) b8();
   serial_add_ctrl_if #(.WIDTH(1)) b1();

   serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
   serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

   typedef struct {
      logic [7:0] sum;
      logic       carry;
      int         cyc;
   } exp_t;

   exp_t q8[$];
   exp_t q1[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor for the 8-bit instance: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && b8.done === 1'b1) begin
         if (q8.size() == 0) begin
            check("dut8_unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q8.pop_front();
            check("dut8_sum", {24'd0, b8.Sum}, {24'd0, e.sum});
            check("dut8_carry", {31'd0, b8.Carry}, {31'd0, e.carry});
            check("dut8_done_cycle", cyc, e.cyc);
         end
      end
   end

   // Monitor for the 1-bit instance.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b0 && b1.done === 1'b1) begin
         if (q1.size() == 0) begin
            check("dut1_unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            check("dut1_sum", {31'd0, b1.Sum}, {31'd0, e.sum[0]});
            check("dut1_carry", {31'd0, b1.Carry}, {31'd0, e.carry});
            check("dut1_done_cycle", cyc, e.cyc);
         end
      end
   end

   // One 8-bit operation; optionally disturbs A/B and re-asserts start during RUN.
   task automatic op8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] esum, input logic ec, input bit disturb);
      logic [7:0] prev_sum;
      logic       prev_c;
      @(negedge clk);
      prev_sum = b8.Sum;
      prev_c   = b8.Carry;
      b8.A = a; b8.B = b; b8.start = 1'b1;
      q8.push_back('{esum, ec, cyc + 1 + 8});
      @(negedge clk);
      check("dut8_busy_after_start", {31'd0, b8.busy}, 32'd1);
      if (disturb) begin
         b8.A = 8'hFF; b8.B = 8'hFF; b8.start = 1'b1;
      end else begin
         b8.start = 1'b0;
      end
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         b8.start = 1'b0;
         check("dut8_busy_run", {31'd0, b8.busy}, 32'd1);
         check("dut8_sum_hold", {23'd0, b8.Carry, b8.Sum}, {23'd0, prev_c, prev_sum});
      end
      @(negedge clk);
      check("dut8_busy_fin", {31'd0, b8.busy}, 32'd0);
      @(negedge clk);
      check("dut8_idle_done", {30'd0, b8.busy, b8.done}, 32'd0);
   endtask

   // One 1-bit operation.
   task automatic op1(input logic a, input logic b, input logic es, input logic ec);
      @(negedge clk);
      b1.A = a; b1.B = b; b1.start = 1'b1;
      q1.push_back('{{7'd0, es}, ec, cyc + 1 + 1});
      @(negedge clk);
      b1.start = 1'b0;
      check("dut1_busy_run", {31'd0, b1.busy}, 32'd1);
      @(negedge clk);
      check("dut1_busy_fin", {31'd0, b1.busy}, 32'd0);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      b8.start = 1'b0; b8.A = 8'h00; b8.B = 8'h00;
      b1.start = 1'b0; b1.A = 1'b0;  b1.B = 1'b0;
      #12;
      check("reset_dut8_outputs", {22'd0, b8.busy, b8.done, b8.Carry, b8.Sum}, 32'd0);
      check("reset_dut1_outputs", {28'd0, b1.busy, b1.done, b1.Carry, b1.Sum}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      op8(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      op8(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      op8(8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b1);

      // Reset in the middle of RUN abandons the operation.
      @(negedge clk);
      b8.A = 8'h80; b8.B = 8'h80; b8.start = 1'b1;
      q8.push_back('{8'h00, 1'b1, cyc + 1 + 8});
      @(negedge clk);
      b8.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrun_reset_outputs", {22'd0, b8.busy, b8.done, b8.Carry, b8.Sum}, 32'd0);
      q8.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("midrun_reset_no_done", {30'd0, b8.busy, b8.done}, 32'd0);
      op8(8'h80, 8'h80, 8'h00, 1'b1, 1'b0);

      // start held high: one completion every WIDTH+2 cycles.
      @(negedge clk);
      b8.A = 8'h0F; b8.B = 8'h01; b8.start = 1'b1;
      q8.push_back('{8'h10, 1'b0, cyc + 1 + 8});
      q8.push_back('{8'h10, 1'b0, cyc + 1 + 18});
      q8.push_back('{8'h10, 1'b0, cyc + 1 + 28});
      repeat (30) @(negedge clk);
      b8.start = 1'b0;
      repeat (3) @(negedge clk);
      check("held_start_idle", {30'd0, b8.busy, b8.done}, 32'd0);

      op1(1'b0, 1'b0, 1'b0, 1'b0);
      op1(1'b0, 1'b1, 1'b1, 1'b0);
      op1(1'b1, 1'b0, 1'b1, 1'b0);
      op1(1'b1, 1'b1, 1'b0, 1'b1);

      repeat (3) @(negedge clk);
      check("dut8_pending_left", q8.size(), 32'd0);
      check("dut1_pending_left", q1.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled on clk rising edge.
REQ-005 Port: A  input  WIDTH  operand A; sampled only when start is accepted.
REQ-006 Port: B  input  WIDTH  operand B; sampled only when start is accepted.
REQ-007 Port: Sum  output  WIDTH  registered result of A+B, modulo 2^WIDTH.
REQ-008 Port: Carry  output  1  registered carry-out of A+B.
REQ-009 Port: busy  output  1  high while an addition is in progress.
REQ-010 Port: done  output  1  one-cycle pulse; Sum and Carry are valid and newly updated.

Function
REQ-011 The design shall use one 1-bit full-adder cell for all bit positions, in time-multiplexed form.
REQ-012 The full-adder cell shall be two instances of the team HA cell (ports A, B, Su, Ca) plus an OR of the two carries.
REQ-013 The FSM shall have three states: IDLE, RUN and FIN; encoding is free.
REQ-014 In IDLE, with start=1 at an edge: latch A and B into shift registers, clear the carry flop, clear the bit counter, and go to RUN.
REQ-015 In IDLE, with start=0: remain in IDLE.
REQ-016 Each RUN edge shall process one bit:
- add the LSB of each shift register and the carry flop;
- shift the result bit into the MSB of a working-sum register;
- shift both operand registers right by one;
- store the carry-out in the carry flop;
- increment the counter.
REQ-017 Bits shall be processed LSB first, one per cycle, over exactly WIDTH RUN edges.
REQ-018 On the RUN edge that processes bit WIDTH-1:
- load the Sum output register with the completed working sum;
- load the Carry output register with that bit's carry-out;
- go to FIN.
REQ-019 FIN shall last one cycle and then return to IDLE unconditionally.
REQ-020 done shall be 1 exactly while in FIN; busy shall be 1 exactly while in RUN.
REQ-021 Latency: start sampled at edge E0 gives busy=1 after E0, and Sum, Carry and done updated after edge E(WIDTH).
REQ-022 start shall be ignored in RUN and FIN; A and B changing during RUN shall not affect the result.
REQ-023 Back-to-back operation: start held high continuously shall be accepted in IDLE on the edge after FIN, one operation every WIDTH+2 cycles.
REQ-024 Sum and Carry shall hold their last values until the next completion; they shall not change during RUN.
REQ-025 The counter width shall be clog2(WIDTH+1) bits, minimum 1.
REQ-026 For WIDTH=1, RUN shall last exactly one cycle.
REQ-027 No combinational path shall exist from any input to any output.

Reset
REQ-028 Asserting rst shall immediately, without waiting for clk, force: state IDLE, Sum=0, Carry=0, busy=0, done=0, counter=0, carry flop=0, operand and working registers=0.
REQ-029 rst asserted mid-operation shall abandon the operation, with no done pulse and Sum/Carry at 0.
REQ-030 After rst deasserts, the first start shall be accepted on the first rising edge where rst=0 and start=1.

Verification
REQ-031 WIDTH=8, A=0x00, B=0x00, start pulse -> busy for 8 cycles, then done=1 for one cycle with Sum=0x00 and Carry=0.
REQ-032 WIDTH=8, A=0xFF, B=0x01 -> done exactly 8 edges after the start edge, with Sum=0x00 and Carry=1 (full carry ripple).
REQ-033 WIDTH=8, A=0xA5, B=0x5A; then during RUN, A=0xFF, B=0xFF and a second start -> Sum=0xFF, Carry=0, a single done, second start ignored.
REQ-034 WIDTH=8, start with A=0x80, B=0x80; rst pulsed at RUN cycle 4 -> immediately busy=0, Sum=0x00, Carry=0, no done; a following start with 0x80+0x80 gives Sum=0x00, Carry=1.
REQ-035 WIDTH=8, start held high with A=0x0F, B=0x01 -> done every 10 cycles, each with Sum=0x10 and Carry=0.
REQ-036 WIDTH=1, all four A/B combinations -> (Sum,Carry) = 00, 10, 10, 01, each with done 1 edge after start.
